seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg_scan_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Bundles the display-side signals of seg_scan_driver: the load/data/blank inputs and the
// registered anode/segment/decimal-point outputs plus the frame_done strobe.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_in;
  logic [NUM_DIGITS-1:0]   AN;
  logic [6:0]              SEG;
  logic                    DP;
  logic                    frame_done;

  modport master (
    output load, digits_in, dp_in, blank_in,
    input  AN, SEG, DP, frame_done
  );

  modport slave (
    input  load, digits_in, dp_in, blank_in,
    output AN, SEG, DP, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                  tick, wrap;
  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] lzb_blank;
  logic                  lead_zero;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick      = (presc_q == PW'(REFRESH_DIV - 1));
  assign wrap      = tick && (idx_q == IW'(NUM_DIGITS - 1));
  assign cur_digit = act_dig_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_LZB_EN
  // Scan from the most significant digit down; a digit is blanked while everything at and
  // above it is zero and it carries no decimal point. Digit 0 is never blanked.
  always_comb begin
    lzb_blank = '0;
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero    = lead_zero && (act_dig_q[4*i +: 4] == 4'h0);
      lzb_blank[i] = (i > 0) && lead_zero && !act_dp_q[i];
    end
  end
`else
  always_comb begin
    lzb_blank = '0;
    lead_zero = 1'b0;
  end
`endif

  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);

    if (wrap && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    // A load coinciding with the wrap becomes the next pending value.
    if (bus.load) begin
      pend_dig_d   = bus.digits_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end

    an_d = ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_q);
    if (bus.blank_in || lzb_blank[idx_q]) an_d = '1;
    seg_d        = decode(cur_digit);
    dp_d         = ~act_dp_q[idx_q];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
// Expectations for blanked slots follow SEG_LZB_EN when it is defined.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S8 = 7'b0000000, SA = 7'b0001000, SOFF = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = p;
    step(1);
    bus.load = 1'b0;
  endtask

  // Advance to the next frame_done pulse, bounded so a stuck scan cannot hang the run.
  task automatic wait_frame();
    int n = 0;
    step(1);
    while (bus.frame_done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check("frame_done_seen", 32'(bus.frame_done), 32'd1);
  endtask

  initial begin
    logic [3:0] an_seq [4];
    int         cnt;
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = 1'b0;

    // Reset state
    step(3);
    check("rst_an", 32'(bus.AN), 32'b1111);
    check("rst_seg", 32'(bus.SEG), 32'(SOFF));
    check("rst_dp", 32'(bus.DP), 32'd1);
    check("rst_fd", 32'(bus.frame_done), 32'd0);

    // Scan order and slot length
    rst = 1'b1;
    step(1);
    check("first_an", 32'(bus.AN), 32'b1110);
    check("first_seg", 32'(bus.SEG), 32'(S0));
    for (int s = 1; s < 4; s++) begin
      step(4);
      check("scan_an", 32'(bus.AN), 32'(an_seq[s]));
    end
    step(3);
    check("wrap_fd", 32'(bus.frame_done), 32'd1);
    check("wrap_an_last", 32'(bus.AN), 32'b0111);
    step(1);
    check("wrap_an0", 32'(bus.AN), 32'b1110);
    check("fd_one_cycle", 32'(bus.frame_done), 32'd0);

    // Load mid-frame (slot 1): held back until the wrap
    step(4);
    check("mid_an1", 32'(bus.AN), 32'b1101);
    do_load(16'h12A8, 4'b0010);
    check("mid_seg_old", 32'(bus.SEG), 32'(S0));
    wait_frame();
    check("pre_wrap_seg", 32'(bus.SEG), 32'(S0));
    step(1);
    check("ld_s0_an", 32'(bus.AN), 32'b1110);
    check("ld_s0_seg", 32'(bus.SEG), 32'(S8));
    check("ld_s0_dp", 32'(bus.DP), 32'd1);
    step(4);
    check("ld_s1_seg", 32'(bus.SEG), 32'(SA));
    check("ld_s1_dp", 32'(bus.DP), 32'd0);
    step(4);
    check("ld_s2_seg", 32'(bus.SEG), 32'(S2));
    check("ld_s2_dp", 32'(bus.DP), 32'd1);
    step(4);
    check("ld_s3_an", 32'(bus.AN), 32'b0111);
    check("ld_s3_seg", 32'(bus.SEG), 32'(S1));

    // Frame period
    wait_frame();
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (bus.frame_done !== 1'b1 && cnt < 40);
    check("frame_period", 32'(cnt), 32'd16);

    // Load coincident with the wrap tick
    step(1);
    do_load(16'h1111, 4'b0000);
    step(13);
    do_load(16'h2222, 4'b0000);
    check("coinc_fd", 32'(bus.frame_done), 32'd1);
    step(1);
    check("coinc_first", 32'(bus.SEG), 32'(S1));
    wait_frame();
    step(1);
    check("coinc_second", 32'(bus.SEG), 32'(S2));

    // Double load within one frame: last value wins
    do_load(16'h3333, 4'b0000);
    step(2);
    do_load(16'h4444, 4'b0000);
    check("dbl_hold", 32'(bus.SEG), 32'(S2));
    wait_frame();
    for (int s = 0; s < 4; s++) begin
      step(s == 0 ? 1 : 4);
      check("dbl_an", 32'(bus.AN), 32'(an_seq[s]));
      check("dbl_seg", 32'(bus.SEG), 32'(S4));
    end

    // Blank for 10 cycles starting in slot 0
    wait_frame();
    step(1);
    bus.blank_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("blank_an", 32'(bus.AN), 32'b1111);
    end
    bus.blank_in = 1'b0;
    step(1);
    check("unblank_s2", 32'(bus.AN), 32'b1011);
    step(1);
    check("unblank_s3", 32'(bus.AN), 32'b0111);

    // Leading zeros
    do_load(16'h0050, 4'b0000);
    wait_frame();
    step(1);
    check("lz_s0_an", 32'(bus.AN), 32'b1110);
    check("lz_s0_seg", 32'(bus.SEG), 32'(S0));
    step(4);
    check("lz_s1_an", 32'(bus.AN), 32'b1101);
    check("lz_s1_seg", 32'(bus.SEG), 32'(S5));
    step(4);
`ifdef SEG_LZB_EN
    check("lz_s2_an", 32'(bus.AN), 32'b1111);
    step(4);
    check("lz_s3_an", 32'(bus.AN), 32'b1111);
`else
    check("lz_s2_an", 32'(bus.AN), 32'b1011);
    check("lz_s2_seg", 32'(bus.SEG), 32'(S0));
    step(4);
    check("lz_s3_an", 32'(bus.AN), 32'b0111);
`endif
    do_load(16'h0000, 4'b0000);
    wait_frame();
    step(1);
    check("zero_s0_an", 32'(bus.AN), 32'b1110);
    check("zero_s0_seg", 32'(bus.SEG), 32'(S0));
    step(4);
`ifdef SEG_LZB_EN
    check("zero_s1_an", 32'(bus.AN), 32'b1111);
`else
    check("zero_s1_an", 32'(bus.AN), 32'b1101);
`endif

    // Reset mid-frame discards a pending load
    do_load(16'h9999, 4'b1111);
    rst = 1'b0;
    step(1);
    check("mrst_an", 32'(bus.AN), 32'b1111);
    check("mrst_seg", 32'(bus.SEG), 32'(SOFF));
    check("mrst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b1;
    step(1);
    check("mrst_rel_an", 32'(bus.AN), 32'b1110);
    check("mrst_rel_seg", 32'(bus.SEG), 32'(S0));
    wait_frame();
    step(1);
    check("mrst_no_pend_seg", 32'(bus.SEG), 32'(S0));
    check("mrst_no_pend_dp", 32'(bus.DP), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
